uart_rx_ctrl: RTL

Oversampling receive sequencer for the UART receiver. Detects and validates the start bit, times the mid-bit samples for data, parity and stop bits, and checks parity and framing. Delivers each good word to the downstream consumer through a valid/ready output register, with overrun detection. Sits between the line synchroniser and baud tick generator on the input side and the receive FIFO or host interface on the output side.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 53 +++++
 rtl/uart_rx_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, default sizes and parity helper for the UART receiver
package uart_pkg;

   localparam int DEF_DATA_BITS  = 8;
   localparam int DEF_OVERSAMPLE = 16;
   localparam int MAX_DATA_BITS  = 9;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } rx_state_t;

   // 1 when the data bits, the received parity bit and the odd/even selector disagree
   function automatic logic parity_bad(logic [MAX_DATA_BITS-1:0] data, logic par_bit, logic odd);
      return (^data) ^ par_bit ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - oversample counter and sample-point strobe for the UART receiver
// UART_RX_MAJORITY_EN selects a 2-of-3 vote over the last three ticks instead of a single sample.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic rst,
   input  logic baud_tick,
   input  logic rx_in,
   input  logic active,
   input  logic half,
   output logic strobe,
   output logic sample
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);

   logic [CW-1:0] scnt;
   logic          at_point;

   // START samples after half a bit; every later bit one full period after the previous sample
   assign at_point = (scnt == (half ? HALF_LAST : FULL_LAST));
   assign strobe   = baud_tick & active & at_point;

   always_ff @(posedge clk) begin
      if (rst || !active) begin
         scnt <= '0;
      end else if (baud_tick) begin
         scnt <= at_point ? '0 : scnt + CW'(1);
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= '0;
      end else if (baud_tick) begin
         hist <= {hist[0], rx_in};
      end
   end

   assign sample = (hist[1] & hist[0]) | (hist[1] & rx_in) | (hist[0] & rx_in);
`else
   assign sample = rx_in;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: start/data/parity/stop timing, error checks, output register
// Optional 2-of-3 sample voting is enabled with UART_RX_MAJORITY_EN (see uart_rx_sampler).
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_t            state;
   logic [BW-1:0]        bcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_fail;
   logic                 active;
   logic                 strobe;
   logic                 sample;

   assign busy   = (state != IDLE);
   assign active = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

   uart_rx_sampler #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_sampler (
      .clk      (clk),
      .rst      (rst),
      .baud_tick(baud_tick),
      .rx_in    (rx_in),
      .active   (active),
      .half     (state == START),
      .strobe   (strobe),
      .sample   (sample)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bcnt        <= '0;
         shreg       <= '0;
         par_fail    <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (baud_tick && !rx_in) begin
                  state <= START;
               end
            end
            START: begin
               if (strobe) begin
                  bcnt  <= '0;
                  state <= sample ? IDLE : DATA;
               end
            end
            DATA: begin
               if (strobe) begin
                  shreg <= {sample, shreg[DATA_BITS-1:1]};
                  if (bcnt == LAST_BIT) begin
                     bcnt     <= '0;
                     par_fail <= 1'b0;
                     state    <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bcnt <= bcnt + BW'(1);
                  end
               end
            end
            PARITY: begin
               if (strobe) begin
                  par_fail <= parity_bad(MAX_DATA_BITS'(shreg), sample, 1'(PARITY_ODD));
                  state    <= STOP;
               end
            end
            STOP: begin
               if (strobe) begin
                  if (!sample) begin
                     frame_err  <= 1'b1;
                     parity_err <= par_fail;
                     state      <= BREAK_WAIT;
                  end else begin
                     state <= IDLE;
                     if (par_fail) begin
                        parity_err <= 1'b1;
                     end else if (rx_valid && !rx_ready) begin
                        overrun_err <= 1'b1;
                     end else begin
                        // overrides the handshake clear above when consume and load coincide
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end
                  end
               end
            end
            BREAK_WAIT: begin
               if (baud_tick && rx_in) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
